// File: rtl/computational_unit_p_if.sv
// Decoder/datapath bundle for computational_unit_p: control, immediate, pin and memory inputs
// plus the bus, register and multiplier status outputs.
interface computational_unit_p_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] ir_imm;
    logic [2:0]       alu_func;
    logic             i_sel;
    logic             x_sel;
    logic             y_sel;
    logic [3:0]       source_sel;
    logic [8:0]       reg_en;
    logic             mul_start;
    logic [WIDTH-1:0] i_pins;
    logic [WIDTH-1:0] dm;
    logic [WIDTH-1:0] data_bus;
    logic [WIDTH-1:0] o_reg;
    logic [WIDTH-1:0] i;
    logic             r_eq_0;
    logic             r_carry;
    logic             mul_busy;
    logic             mul_done;

    modport master (
        output ir_imm, alu_func, i_sel, x_sel, y_sel, source_sel, reg_en, mul_start, i_pins, dm,
        input  data_bus, o_reg, i, r_eq_0, r_carry, mul_busy, mul_done
    );

    modport slave (
        input  ir_imm, alu_func, i_sel, x_sel, y_sel, source_sel, reg_en, mul_start, i_pins, dm,
        output data_bus, o_reg, i, r_eq_0, r_carry, mul_busy, mul_done
    );
endinterface

// File: rtl/computational_unit_p.sv
// Nibble-processor datapath: register file, ALU with carry/borrow flag, data bus mux and a
// sequential shift-add multiplier with busy/done handshake.
module computational_unit_p #(
    parameter int WIDTH = 4
) (
    input logic                  clk,
    input logic                  sync_reset,
    computational_unit_p_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

    mul_state_t       state, state_nx;
    logic [WIDTH-1:0] x0, x1, y0, y1, r, m, i_reg, o_reg;
    logic             r_eq_0, r_carry;
    logic [PW-1:0]    product, mcand, acc, acc_step;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] x_op, y_op, alu_out, data_bus;
    logic             alu_carry;
    logic [WIDTH:0]   sum_ext, diff_ext;
    logic             start_ok, last_step, r_hold;
    logic             unused_reg_en7;

    assign unused_reg_en7 = bus.reg_en[7];

    assign x_op     = bus.x_sel ? x1 : x0;
    assign y_op     = bus.y_sel ? y1 : y0;
    assign sum_ext  = {1'b0, x_op} + {1'b0, y_op};
    assign diff_ext = {1'b0, x_op} - {1'b0, y_op};
    assign acc_step = mplier[0] ? acc + mcand : acc;

    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b0;
        case (bus.alu_func)
            3'd0: alu_out = bus.y_sel ? r : -x_op;
            3'd1: begin
                alu_out   = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
            end
            3'd2: begin
                alu_out   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            3'd3: alu_out = product[PW-1:WIDTH];
            3'd4: alu_out = product[WIDTH-1:0];
            3'd5: alu_out = x_op ^ y_op;
            3'd6: alu_out = x_op & y_op;
            default: alu_out = bus.y_sel ? r : ~x_op;
        endcase
    end

    always_comb begin
        data_bus = '0;
        case (bus.source_sel)
            4'h0: data_bus = x0;
            4'h1: data_bus = x1;
            4'h2: data_bus = y0;
            4'h3: data_bus = y1;
            4'h4: data_bus = r;
            4'h5: data_bus = m;
            4'h6: data_bus = i_reg;
            4'h7: data_bus = bus.dm;
            4'h8: data_bus = bus.ir_imm;
            4'h9: data_bus = bus.i_pins;
            4'hA: data_bus = product[WIDTH-1:0];
            4'hB: data_bus = product[PW-1:WIDTH];
            default: data_bus = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) state <= IDLE;
        else            state <= state_nx;
    end

    // DONE accepts a new start exactly like IDLE so multiplies can run back to back
    always_comb begin
        state_nx  = state;
        start_ok  = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.mul_start) begin
                    start_ok = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (count == CW'(WIDTH - 1)) begin
                    last_step = 1'b1;
                    state_nx  = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
        end else if (start_ok) begin
            mcand  <= {{WIDTH{1'b0}}, x_op};
            mplier <= y_op;
            acc    <= '0;
            count  <= '0;
        end else if (state == RUN) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (last_step) product <= acc_step;
        end
    end

    // Product reads into r are frozen while the multiplier is still running
    assign r_hold = ((bus.alu_func == 3'd3) || (bus.alu_func == 3'd4)) && (state == RUN);

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            x0      <= '0;
            x1      <= '0;
            y0      <= '0;
            y1      <= '0;
            r       <= '0;
            m       <= '0;
            i_reg   <= '0;
            o_reg   <= '0;
            r_eq_0  <= 1'b1;
            r_carry <= 1'b0;
        end else begin
            if (bus.reg_en[0]) x0 <= data_bus;
            if (bus.reg_en[1]) x1 <= data_bus;
            if (bus.reg_en[2]) y0 <= data_bus;
            if (bus.reg_en[3]) y1 <= data_bus;
            if (bus.reg_en[4] && !r_hold) begin
                r       <= alu_out;
                r_eq_0  <= (alu_out == '0);
                r_carry <= alu_carry;
            end
            if (bus.reg_en[5]) m <= data_bus;
            if (bus.reg_en[6]) i_reg <= bus.i_sel ? i_reg + m : data_bus;
            if (bus.reg_en[8]) o_reg <= data_bus;
        end
    end

    assign bus.data_bus = data_bus;
    assign bus.o_reg    = o_reg;
    assign bus.i        = i_reg;
    assign bus.r_eq_0   = r_eq_0;
    assign bus.r_carry  = r_carry;
    assign bus.mul_busy = (state == RUN);
    assign bus.mul_done = (state == DONE);
endmodule

// File: tb/tb_computational_unit_p.sv
// Scoreboard bench for computational_unit_p: a cycle-level reference model predicts every
// observable output, and a negedge monitor compares the DUT against the queued predictions.
module tb_computational_unit_p;
    localparam int W = 4;
    localparam int M = (1 << W) - 1;

    typedef struct {
        int db;
        int oreg;
        int iv;
        bit eq;
        bit cy;
        bit busy;
        bit done;
    } snap_t;

    logic clk = 1'b0;
    logic sync_reset;
    always #5 clk = ~clk;

    computational_unit_p_if #(.WIDTH(W)) bus ();
    computational_unit_p #(.WIDTH(W)) dut (
        .clk       (clk),
        .sync_reset(sync_reset),
        .bus       (bus)
    );

    snap_t q[$];
    int    n_vec = 0;
    int    n_err = 0;
    bit    chk_en = 1'b0;

    int x0, x1, y0, y1, r, m, iv, oreg, prod, pend, run_left;
    bit eq, cy, done;

    task automatic reset_model();
        x0 = 0; x1 = 0; y0 = 0; y1 = 0; r = 0; m = 0; iv = 0; oreg = 0;
        prod = 0; pend = 0; run_left = 0;
        eq = 1'b1; cy = 1'b0; done = 1'b0;
    endtask

    function automatic int bus_model(int sel, int imm, int pins, int dmv);
        case (sel)
            0: return x0;
            1: return x1;
            2: return y0;
            3: return y1;
            4: return r;
            5: return m;
            6: return iv;
            7: return dmv;
            8: return imm;
            9: return pins;
            10: return prod & M;
            11: return (prod >> W) & M;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic step(input bit rst, input int sel, input int en, input int f, input bit xs,
                        input bit ys, input bit isel, input bit ms, input int imm, input int pins,
                        input int dmv);
        int    xv, yv, db, ao, ni;
        bit    c;
        snap_t s;
        sync_reset     = rst;
        bus.source_sel = sel[3:0];
        bus.reg_en     = en[8:0];
        bus.alu_func   = f[2:0];
        bus.x_sel      = xs;
        bus.y_sel      = ys;
        bus.i_sel      = isel;
        bus.mul_start  = ms;
        bus.ir_imm     = imm[W-1:0];
        bus.i_pins     = pins[W-1:0];
        bus.dm         = dmv[W-1:0];
        xv = xs ? x1 : x0;
        yv = ys ? y1 : y0;
        db = bus_model(sel, imm, pins, dmv);
        c  = 1'b0;
        case (f)
            0: ao = ys ? r : (-xv) & M;
            1: begin ao = (xv - yv) & M; c = (xv < yv); end
            2: begin ao = (xv + yv) & M; c = (xv + yv) > M; end
            3: ao = (prod >> W) & M;
            4: ao = prod & M;
            5: ao = xv ^ yv;
            6: ao = xv & yv;
            default: ao = ys ? r : (~xv) & M;
        endcase
        if (chk_en) begin
            s.db = db; s.oreg = oreg; s.iv = iv; s.eq = eq; s.cy = cy;
            s.busy = (run_left > 0); s.done = done;
            q.push_back(s);
            n_vec++;
        end
        @(posedge clk);
        if (rst) begin
            reset_model();
        end else begin
            ni = isel ? (iv + m) & M : db;
            if (en[0]) x0 = db;
            if (en[1]) x1 = db;
            if (en[2]) y0 = db;
            if (en[3]) y1 = db;
            if (en[4] && !((f == 3 || f == 4) && run_left > 0)) begin
                r = ao; eq = (ao == 0); cy = c;
            end
            if (en[5]) m = db;
            if (en[6]) iv = ni;
            if (en[8]) oreg = db;
            if (run_left > 0) begin
                run_left--;
                if (run_left == 0) begin
                    prod = pend;
                    done = 1'b1;
                end
            end else begin
                done = 1'b0;
                if (ms) begin
                    pend = xv * yv;
                    run_left = W;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int sel);
        step(0, sel, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            snap_t s;
            s = q.pop_front();
            chk("data_bus", 32'(bus.data_bus), 32'(s.db));
            chk("o_reg", 32'(bus.o_reg), 32'(s.oreg));
            chk("i", 32'(bus.i), 32'(s.iv));
            chk("r_eq_0", 32'(bus.r_eq_0), 32'(s.eq));
            chk("r_carry", 32'(bus.r_carry), 32'(s.cy));
            chk("mul_busy", 32'(bus.mul_busy), 32'(s.busy));
            chk("mul_done", 32'(bus.mul_done), 32'(s.done));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int s = 0; s <= 6; s++) idle(s);
        idle(10);
        idle(11);

        // 9 + 8 -> 1 with carry, then 3 - 5 -> E with borrow
        step(0, 8, 'h001, 0, 0, 0, 0, 0, 9, 0, 0);
        step(0, 8, 'h004, 0, 0, 0, 0, 0, 8, 0, 0);
        step(0, 0, 'h010, 2, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        step(0, 8, 'h001, 0, 0, 0, 0, 0, 3, 0, 0);
        step(0, 8, 'h004, 0, 0, 0, 0, 0, 5, 0, 0);
        step(0, 0, 'h010, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(4);

        // F * F = E1
        step(0, 8, 'h001, 0, 0, 0, 0, 0, 15, 0, 0);
        step(0, 8, 'h008, 0, 0, 0, 0, 0, 15, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) idle(11);
        step(0, 4, 'h010, 3, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        step(0, 4, 'h010, 4, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        idle(10);
        idle(11);

        // 3 * 5 with x0 overwrite and restart attempt during RUN, product load while busy
        step(0, 8, 'h001, 0, 0, 0, 0, 0, 3, 0, 0);
        step(0, 8, 'h004, 0, 0, 0, 0, 0, 5, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 8, 'h001, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 'h010, 4, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) idle(4);
        idle(10);
        idle(11);

        // reset in the second RUN cycle
        step(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        idle(10);
        step(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) idle(10);
        idle(11);

        // index wrap and output port
        step(0, 8, 'h020, 0, 0, 0, 0, 0, 7, 0, 0);
        step(0, 8, 'h040, 0, 0, 0, 0, 0, 12, 0, 0);
        step(0, 6, 'h040, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(6);
        step(0, 9, 'h100, 0, 0, 0, 0, 0, 0, 10, 0);
        idle(9);

        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 15), $urandom_range(0, 511),
                 $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom_range(0, M),
                 $urandom_range(0, M), $urandom_range(0, M));
        end
        idle(0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/computational_unit_p.md
Name: computational_unit_p

Overview:
- Parametrised next-generation datapath for the nibble microprocessor.
- Data width is set by WIDTH.
- Adds a sequential shift-add multiplier with a busy/done handshake, a carry/borrow flag on the result register, and bus access to the product register.
- Sits between the instruction decoder (which drives source_sel, reg_en, alu_func, selects and mul_start) and the data memory / I/O pins.

Parameters:
- WIDTH, 4, datapath width of all registers, bus, immediate and pins; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- sync_reset  input  1  synchronous, active-high reset
- ir_imm  input  WIDTH  immediate field from instruction (pm_data source)
- alu_func  input  3  ALU function select
- i_sel  input  1  1: i <= i + m; 0: i <= data_bus
- x_sel  input  1  ALU x operand: 1 = x1, 0 = x0
- y_sel  input  1  ALU y operand: 1 = y1, 0 = y0; also modifies funcs 0/7
- source_sel  input  4  data_bus source select
- reg_en  input  9  load enables: [0]x0 [1]x1 [2]y0 [3]y1 [4]r+flags [5]m [6]i [7]reserved [8]o_reg
- mul_start  input  1  start multiply of current x,y
- i_pins  input  WIDTH  external input pins
- dm  input  WIDTH  data-memory read data
- data_bus  output  WIDTH  internal bus (combinational)
- o_reg  output  WIDTH  output port register
- i  output  WIDTH  index register
- r_eq_0  output  1  r == 0 flag, registered with r
- r_carry  output  1  carry/borrow flag, registered with r
- mul_busy  output  1  multiplier running
- mul_done  output  1  one-cycle pulse when product register valid

Behaviour:
- Reset (sync_reset high at edge):
  - x0, x1, y0, y1, r, m, i, o_reg, product register = 0.
  - r_eq_0 = 1, r_carry = 0, mul_busy = 0, mul_done = 0.
  - Any multiply in flight is aborted.
- data_bus by source_sel:
  - 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 ir_imm, 9 i_pins.
  - A product low WIDTH bits, B product high WIDTH bits.
  - C..F = 0.
- ALU (combinational, modulo 2^WIDTH):
  - 0: y_sel ? r : -x
  - 1: x - y; carry = borrow (1 when x < y, unsigned)
  - 2: x + y; carry = carry-out
  - 3: product high half
  - 4: product low half
  - 5: x ^ y
  - 6: x & y
  - 7: y_sel ? r : ~x
  - Carry is 0 for all functions other than 1 and 2.
  - The ALU output is never zeroed by reset; only the registers reset.
- r load (reg_en[4]): at the edge, r <= alu_out, r_eq_0 <= (alu_out == 0), r_carry <= carry.
  - Exception: funcs 3/4 while mul_busy = 1 leave r, r_eq_0 and r_carry unchanged.
- x0/x1/y0/y1/m/o_reg load data_bus when their enable is set; otherwise they hold.
- i load (reg_en[6]): i_sel ? i + m : data_bus, wrapping modulo 2^WIDTH. reg_en[7] has no effect.
- Multiplier FSM, states IDLE -> RUN -> DONE:
  - IDLE: mul_start = 1 at an edge captures multiplicand = x and multiplier = y (selected by the x_sel/y_sel values in that cycle), clears the accumulator and goes to RUN with count = 0.
  - RUN: one unsigned shift-add step per cycle; mul_busy = 1 for exactly WIDTH cycles.
  - At the edge ending the last RUN cycle: product register <= full 2*WIDTH-bit result, state -> DONE.
  - DONE: mul_done = 1 and mul_busy = 0 for one cycle, then -> IDLE.
  - mul_start in DONE is accepted exactly as in IDLE, giving back-to-back operation.
  - mul_start during RUN is ignored.
  - The product register is written only at completion and otherwise holds its previous result.
  - Writes to x/y during RUN do not affect the operation in flight.
  - sync_reset mid-RUN returns to IDLE with the product register = 0 and no mul_done pulse.
- Latency:
  - mul_start sampled at edge N.
  - mul_busy high for cycles N+1 .. N+WIDTH.
  - Product register valid and mul_done high in cycle N+WIDTH+1.
- Simultaneous events:
  - reg_en[4] with func 3/4 in the mul_done cycle loads the new product.
  - Reset has priority over all loads.

Test Plan:
- Reset, then WIDTH=4: all registers read 0 via source_sel 0..6 and A/B; r_eq_0 = 1, r_carry = 0, mul_busy = 0.
- Load x0=9 and y0=8 via ir_imm, func 2 with reg_en[4] -> r = 1, r_carry = 1, r_eq_0 = 0. Then func 1 with x0=3, y0=5 -> r = E, r_carry = 1.
- x0=F, y1=F (y_sel=1), pulse mul_start -> mul_busy high exactly 4 cycles, then mul_done pulse. Func 3 -> r = E; func 4 -> r = 1; source_sel A/B show 1/E.
- Start multiply 3*5, overwrite x0 with 0 and pulse mul_start again during RUN -> product = 0F, only one mul_done. Func 4 load during busy leaves r unchanged.
- sync_reset asserted in the 2nd RUN cycle -> mul_busy = 0 next cycle, no mul_done, product = 0.
- m=7, i=C, reg_en[6] with i_sel=1 -> i = 3 (wrap). Then reg_en[8] with source_sel 9 and i_pins=A -> o_reg = A.
